data_ram_responder: RTL and testbench
=====================================

# data_ram_responder

Memory-side responder for the pipeline's data-memory interface: accepts the core's MEM-stage address/data/write strobe and returns read data in the same cycle, so the MEM/WB register captures it on the next edge. Holds a word-addressed RAM, a small memory-mapped I/O window (GPIO output register, free-running cycle counter), and a host valid/ready port for loading and inspecting memory. Sits beside the core at top level, wired directly to its RAM_* ports.

## Interface
- DEPTH, 256: RAM size in 32-bit words; power of two, at least 4.
- MMIO_BASE, 32'h0000_FF00: word address of the MMIO window; must be at least DEPTH.
- clk  in  1  single clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
- RAM_IN_ADDRESS  in  32  core word address (MEM-stage ALU result).
- RAM_IN_DATA  in  32  core store data.
- RAM_IN_WRITE  in  1  core store strobe.
- RAM_OUT  out  32  core load data; combinational from RAM_IN_ADDRESS.
- host_valid  in  1  host request valid.
- host_ready  out  1  request accepted this cycle.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  32  host word address.
- host_wdata  in  32  host write data.
- host_rdata  out  32  registered host read data.
- host_rvalid  out  1  one-cycle pulse; host_rdata valid.
- gpio_out  out  32  GPIO register (MMIO_BASE+0).
- busy  out  1  clear sequence in progress (see Configuration).

## Operation
- Address decode, identical for core and host:
  - addr < DEPTH: RAM word addr[log2(DEPTH)-1:0].
  - MMIO_BASE+0: gpio_out; read/write.
  - MMIO_BASE+1: cycle counter; read-only, writes ignored.
  - Anything else: reads return 0, writes are dropped.
- Core read: RAM_OUT = decoded word for RAM_IN_ADDRESS, with no latency. A read never has side effects.
- Core write: when RAM_IN_WRITE=1, the target is updated at the rising edge.
- Cycle counter: 32-bit. Increments every cycle outside reset and wraps from FFFF_FFFF to 0.
- Host port:
  - host_ready = !busy && !(RAM_IN_WRITE && host_we).
  - A transfer occurs when host_valid && host_ready.
  - The host must hold its request stable until it is accepted.
- Host write: commits at the accepting edge. The core has priority; host and core writes are never committed in the same cycle.
- Host read:
  - Accepted when not busy, even if the core is writing.
  - host_rdata is registered at the accepting edge and host_rvalid pulses the following cycle.
  - The value returned is the pre-edge contents. A core write to the same address in the accepting cycle is not visible in host_rdata.
- Back-to-back host requests are allowed: one per cycle, with pipelined rvalid pulses.

## Timing
- Reset, held while clr=1:
  - gpio_out=0, counter=0, host_rdata=0, host_rvalid=0.
  - With DRAM_CLEAR_EN, FSM enters CLEAR with index 0 and busy=1. Without it, busy=0.
  - RAM contents are not reset by clr.
- Reset asserted mid-operation: all registers revert on the next edge. A pending host_rvalid is cancelled. Any write in that same cycle is dropped.
- RAM_OUT to MEM/WB capture: zero-cycle path. A store at edge N is visible to a load presented in the cycle after N.
- host_rvalid latency: exactly 1 cycle after acceptance.
- host_ready is combinational from RAM_IN_WRITE, host_we and busy.

## Configuration
- DRAM_CLEAR_EN defined:
  - FSM states CLEAR → RUN.
  - CLEAR writes 0 to word index 0..DEPTH-1, one per cycle, then enters RUN after index DEPTH-1.
  - busy=1 throughout CLEAR, i.e. exactly DEPTH cycles after clr deasserts.
  - During CLEAR: core and host writes are dropped, host_ready=0, RAM_OUT returns 0 for RAM addresses, and MMIO operates normally.
  - clr during CLEAR restarts at index 0.
- Undefined: no FSM, busy tied 0, and RAM contents are retained across clr.

## Test plan
- Core store/load: write 0xDEADBEEF to addr 5 at edge N; RAM_IN_ADDRESS=5 in cycle N+1 → RAM_OUT=0xDEADBEEF. Addr 300 (DEPTH=256) → RAM_OUT=0, and the write is dropped.
- MMIO: core writes 0x0000_00A5 to 0xFF00 → gpio_out=0xA5 next cycle. Two reads of 0xFF01 taken 10 cycles apart differ by 10. A write to 0xFF01 is ignored.
- Host/core collision: host_valid, host_we=1, addr 7 while RAM_IN_WRITE=1 to addr 8 → host_ready=0. Next cycle RAM_IN_WRITE=0 → accepted; addr 7 and addr 8 both hold their written data.
- Host read: host loads addr 3 = 0x1234. Read of addr 3 → host_rvalid exactly 1 cycle later with host_rdata=0x1234. Three back-to-back reads → three consecutive rvalid pulses.
- Reset mid-operation: set gpio_out=0xFF, issue a host read, assert clr in the acceptance-plus-one cycle → host_rvalid=0, gpio_out=0, counter=0 after the edge.
- DRAM_CLEAR_EN (DEPTH=16): preload addr 9 = 0x55. After clr, busy=1 for exactly 16 cycles and host_ready=0 throughout. Afterwards a read of addr 9 returns 0.

Source files
------------

// File: rtl/data_ram_responder.sv
// data_ram_responder: data-memory responder that sits beside the core.
// Serves the core's MEM-stage load/store port combinationally, owns a small
// MMIO window (GPIO output register at MMIO_BASE+0, free-running cycle
// counter at MMIO_BASE+1) and offers a host valid/ready port for loading and
// inspecting memory.
//
// Optional feature macro: DRAM_CLEAR_EN. When defined, a two-state FSM
// (CLEAR -> RUN) zeroes every RAM word after reset, one word per cycle, and
// holds busy high while it does so. When undefined there is no FSM, busy is
// tied low and RAM contents survive clr.
//
// Host handshake: a request is presented with host_valid and held stable
// (host_we/host_addr/host_wdata) until host_valid && host_ready is seen at a
// rising edge; that edge is the transfer. host_ready drops while busy, or
// while the core stores in the same cycle that the host wants to write, so
// core and host writes are never committed together. Reads are accepted
// alongside a core store; their data is registered at the accepting edge
// (pre-edge contents) and host_rvalid pulses for the one following cycle.
module data_ram_responder #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'h0000_FF00
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] RAM_IN_ADDRESS,
  input  logic [31:0] RAM_IN_DATA,
  input  logic        RAM_IN_WRITE,
  output logic [31:0] RAM_OUT,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  output logic [31:0] gpio_out,
  output logic        busy
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [31:0] GPIO_ADDR = MMIO_BASE;
  localparam logic [31:0] CNT_ADDR  = MMIO_BASE + 32'd1;

  // Target of an address after decode; shared by core and host.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO,
    SEL_CNT
  } sel_e;

  function automatic sel_e decode(input logic [31:0] addr);
    sel_e sel;
    sel = SEL_NONE;
    if (addr < DEPTH_W)        sel = SEL_RAM;
    else if (addr == GPIO_ADDR) sel = SEL_GPIO;
    else if (addr == CNT_ADDR)  sel = SEL_CNT;
    return sel;
  endfunction

  // Storage and MMIO registers
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_gpio;
  logic [31:0] r_counter;
  logic [31:0] r_host_rdata;
  logic        r_host_rvalid;

  // Clear-sequence signals (constant when the feature is compiled out)
  logic          w_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_idx;

  // Decode results
  sel_e          w_core_sel;
  sel_e          w_host_sel;
  logic [AW-1:0] w_core_idx;
  logic [AW-1:0] w_host_idx;
  logic [31:0]   w_core_rdata;
  logic [31:0]   w_host_rd_word;

  // Transfer qualifiers
  logic w_host_xfer;
  logic w_host_rd;
  logic w_host_wr;
  logic w_core_wr;

  // Merged write port (core has priority over host)
  logic          w_wr_en;
  sel_e          w_wr_sel;
  logic [AW-1:0] w_wr_idx;
  logic [31:0]   w_wr_data;

`ifdef DRAM_CLEAR_EN
  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_clr_idx;
  logic [AW-1:0] w_clr_idx_nxt;

  // Clear FSM state register; clr (re)starts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Clear FSM next state: one zero write per cycle, leave after the last word.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_clr_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_idx == AW'(DEPTH - 1)) begin
          w_state_nxt   = ST_RUN;
          w_clr_idx_nxt = '0;
        end else begin
          w_clr_idx_nxt = r_clr_idx + AW'(1);
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  assign w_busy    = (r_state == ST_CLEAR);
  assign w_clr_idx = r_clr_idx;
`else
  assign w_busy    = 1'b0;
  assign w_clr_we  = 1'b0;
  assign w_clr_idx = '0;
`endif

  assign w_core_sel = decode(RAM_IN_ADDRESS);
  assign w_host_sel = decode(host_addr);
  assign w_core_idx = RAM_IN_ADDRESS[AW-1:0];
  assign w_host_idx = host_addr[AW-1:0];

  // Core load mux; RAM words read as zero while the clear sweep is running.
  always_comb begin
    w_core_rdata = '0;
    case (w_core_sel)
      SEL_RAM:  w_core_rdata = w_busy ? 32'd0 : r_mem[w_core_idx];
      SEL_GPIO: w_core_rdata = r_gpio;
      SEL_CNT:  w_core_rdata = r_counter;
      default:  w_core_rdata = '0;
    endcase
  end

  // Host read mux; host reads are only accepted when not busy.
  always_comb begin
    w_host_rd_word = '0;
    case (w_host_sel)
      SEL_RAM:  w_host_rd_word = r_mem[w_host_idx];
      SEL_GPIO: w_host_rd_word = r_gpio;
      SEL_CNT:  w_host_rd_word = r_counter;
      default:  w_host_rd_word = '0;
    endcase
  end

  assign host_ready  = !w_busy && !(RAM_IN_WRITE && host_we);
  assign w_host_xfer = host_valid && host_ready;
  assign w_host_rd   = w_host_xfer && !host_we;
  assign w_host_wr   = w_host_xfer && host_we && !clr;
  assign w_core_wr   = RAM_IN_WRITE && !w_busy && !clr;

  // Write arbitration: a host write only reaches here when the core is idle.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_sel  = SEL_NONE;
    w_wr_idx  = '0;
    w_wr_data = '0;
    if (w_core_wr) begin
      w_wr_en   = 1'b1;
      w_wr_sel  = w_core_sel;
      w_wr_idx  = w_core_idx;
      w_wr_data = RAM_IN_DATA;
    end else if (w_host_wr) begin
      w_wr_en   = 1'b1;
      w_wr_sel  = w_host_sel;
      w_wr_idx  = w_host_idx;
      w_wr_data = host_wdata;
    end
  end

  // RAM array: no reset; clear sweep zeroes words, otherwise merged write port.
  always_ff @(posedge clk) begin
    if (w_clr_we && !clr) begin
      r_mem[w_clr_idx] <= 32'd0;
    end else if (w_wr_en && (w_wr_sel == SEL_RAM)) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  // GPIO output register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_gpio <= '0;
    end else if (w_wr_en && (w_wr_sel == SEL_GPIO)) begin
      r_gpio <= w_wr_data;
    end
  end

  // Free-running cycle counter; writes to its address are ignored.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_counter <= '0;
    end else begin
      r_counter <= r_counter + 32'd1;
    end
  end

  // Host read return: capture pre-edge data, pulse rvalid for one cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_host_rvalid <= w_host_rd;
      if (w_host_rd) begin
        r_host_rdata <= w_host_rd_word;
      end
    end
  end

  assign RAM_OUT     = w_core_rdata;
  assign host_rdata  = r_host_rdata;
  assign host_rvalid = r_host_rvalid;
  assign gpio_out    = r_gpio;
  assign busy        = w_busy;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: directed vectors with literal expectations,
// plus a memory-map model checked against the DUT at every falling edge.
module tb_data_ram_responder;

`ifdef DRAM_CLEAR_EN
  localparam int TB_DEPTH   = 16;
  localparam bit CLEAR_MODE = 1'b1;
`else
  localparam int TB_DEPTH   = 256;
  localparam bit CLEAR_MODE = 1'b0;
`endif
  localparam logic [31:0] BASE  = 32'h0000_FF00;
  localparam logic [31:0] ALIAS = 32'(300 % TB_DEPTH);

  logic        clk;
  logic        clr;
  logic [31:0] RAM_IN_ADDRESS;
  logic [31:0] RAM_IN_DATA;
  logic        RAM_IN_WRITE;
  logic [31:0] RAM_OUT;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic [31:0] gpio_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  data_ram_responder #(
    .DEPTH(TB_DEPTH),
    .MMIO_BASE(BASE)
  ) dut (
    .clk(clk),
    .clr(clr),
    .RAM_IN_ADDRESS(RAM_IN_ADDRESS),
    .RAM_IN_DATA(RAM_IN_DATA),
    .RAM_IN_WRITE(RAM_IN_WRITE),
    .RAM_OUT(RAM_OUT),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .gpio_out(gpio_out),
    .busy(busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [TB_DEPTH];
  bit          m_known [TB_DEPTH];
  logic [31:0] m_gpio = '0;
  logic [31:0] m_rd = '0;
  bit          m_rd_known = 1'b0;
  bit          m_rv = 1'b0;
  bit          m_started = 1'b0;
  int          m_cyc = 0;
  int          m_last_clr = 0;
  int          m_clear_left = 0;

  // What a read of address a returns right now.
  function automatic logic [31:0] m_read(input logic [31:0] a, input bit core, output bit known);
    known = 1'b1;
    if (a < 32'(TB_DEPTH)) begin
      if (core && m_clear_left > 0) return 32'd0;
      known = m_known[int'(a)];
      return m_mem[int'(a)];
    end
    if (a == BASE) return m_gpio;
    if (a == BASE + 32'd1) return 32'(m_cyc - m_last_clr);
    return 32'd0;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    if (a < 32'(TB_DEPTH)) begin
      m_mem[int'(a)]   = d;
      m_known[int'(a)] = 1'b1;
    end else if (a == BASE) begin
      m_gpio = d;
    end
  endtask

  // Model advance at each rising edge from the pre-edge inputs.
  always @(posedge clk) begin
    bit          busy_m;
    bit          rdy_m;
    bit          k;
    logic [31:0] v;
    busy_m = (m_clear_left > 0);
    rdy_m  = !busy_m && !(RAM_IN_WRITE && host_we);
    if (clr) begin
      m_gpio       = '0;
      m_rd         = '0;
      m_rd_known   = 1'b1;
      m_rv         = 1'b0;
      m_clear_left = CLEAR_MODE ? TB_DEPTH : 0;
      m_cyc++;
      m_last_clr   = m_cyc;
      m_started    = 1'b1;
    end else begin
      m_rv = host_valid && rdy_m && !host_we;
      if (m_rv) begin
        v          = m_read(host_addr, 1'b0, k);
        m_rd       = v;
        m_rd_known = k;
      end
      if (RAM_IN_WRITE && !busy_m) m_write(RAM_IN_ADDRESS, RAM_IN_DATA);
      else if (host_valid && rdy_m && host_we) m_write(host_addr, host_wdata);
      if (m_clear_left > 0) begin
        m_mem[TB_DEPTH - m_clear_left]   = '0;
        m_known[TB_DEPTH - m_clear_left] = 1'b1;
        m_clear_left--;
      end
      m_cyc++;
    end
  end

  // Scoreboard compare on every falling edge once reset has been seen.
  always @(negedge clk) begin
    bit          k;
    logic [31:0] e;
    if (m_started) begin
      e = m_read(RAM_IN_ADDRESS, 1'b1, k);
      if (k) check("sb_ram_out", RAM_OUT, e);
      check("sb_host_ready", 32'(host_ready), 32'((m_clear_left == 0) && !(RAM_IN_WRITE && host_we)));
      check("sb_busy", 32'(busy), 32'(m_clear_left > 0));
      check("sb_gpio", gpio_out, m_gpio);
      check("sb_rvalid", 32'(host_rvalid), 32'(m_rv));
      if (m_rd_known) check("sb_rdata", host_rdata, m_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_wr(input logic [31:0] a, input logic [31:0] d);
    RAM_IN_ADDRESS = a;
    RAM_IN_DATA    = d;
    RAM_IN_WRITE   = 1'b1;
    tick();
    RAM_IN_WRITE   = 1'b0;
  endtask

  task automatic core_rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    RAM_IN_ADDRESS = a;
    #1;
    check(name, RAM_OUT, exp);
  endtask

  task automatic host_wr(input logic [31:0] a, input logic [31:0] d);
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_valid = 1'b0;
    host_we    = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] v1, v2, v3;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp [3];
    int          busy_cycles;

    clr = 1'b1; RAM_IN_ADDRESS = '0; RAM_IN_DATA = '0; RAM_IN_WRITE = 1'b0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (2) tick();
    clr = 1'b0;

    // Reset state
    core_rd_chk("rst_counter", BASE + 32'd1, 32'd0);
    check("rst_gpio", gpio_out, 32'd0);
    check("rst_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_rdata", host_rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'(CLEAR_MODE));
    wait_idle();

    // Core store then load in the following cycle; out-of-range write dropped
    core_wr(32'd5, 32'hDEAD_BEEF);
    core_rd_chk("core_load_5", 32'd5, 32'hDEAD_BEEF);
    core_wr(ALIAS, 32'h0000_4444);
    core_wr(32'd300, 32'h0000_1111);
    core_rd_chk("oob_read_300", 32'd300, 32'd0);
    core_rd_chk("oob_no_alias", ALIAS, 32'h0000_4444);
    core_wr(32'd10, 32'h0000_1010);
    core_wr(32'd9, 32'h0000_0055);

    // MMIO: GPIO, counter, unmapped
    core_wr(BASE, 32'h0000_00A5);
    check("gpio_a5", gpio_out, 32'h0000_00A5);
    core_rd_chk("gpio_read", BASE, 32'h0000_00A5);
    RAM_IN_ADDRESS = BASE + 32'd1;
    #1 v1 = RAM_OUT;
    repeat (10) tick();
    v2 = RAM_OUT;
    check("counter_delta10", v2 - v1, 32'd10);
    core_wr(BASE + 32'd1, 32'd0);
    v3 = RAM_OUT;
    check("counter_write_ignored", v3, v2 + 32'd1);
    core_wr(BASE + 32'd2, 32'h0000_CAFE);
    core_rd_chk("unmapped_read", BASE + 32'd2, 32'd0);

    // Host write colliding with a core store
    host_valid = 1'b1; host_we = 1'b1; host_addr = 32'd7; host_wdata = 32'h0000_0077;
    RAM_IN_ADDRESS = 32'd8; RAM_IN_DATA = 32'h0000_0088; RAM_IN_WRITE = 1'b1;
    #1 check("collide_ready0", 32'(host_ready), 32'd0);
    tick();
    RAM_IN_WRITE = 1'b0;
    #1 check("collide_ready1", 32'(host_ready), 32'd1);
    tick();
    host_valid = 1'b0; host_we = 1'b0;
    core_rd_chk("collide_addr7", 32'd7, 32'h0000_0077);
    core_rd_chk("collide_addr8", 32'd8, 32'h0000_0088);

    // Host read: rvalid exactly one cycle after acceptance
    host_wr(32'd3, 32'h0000_1234);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 32'd3;
    #1 check("hrd_rvalid_before", 32'(host_rvalid), 32'd0);
    tick();
    host_valid = 1'b0;
    check("hrd_rvalid", 32'(host_rvalid), 32'd1);
    check("hrd_rdata", host_rdata, 32'h0000_1234);
    tick();
    check("hrd_rvalid_drop", 32'(host_rvalid), 32'd0);

    // Three back-to-back host reads
    b2b_addr[0] = 32'd3; b2b_exp[0] = 32'h0000_1234;
    b2b_addr[1] = 32'd5; b2b_exp[1] = 32'hDEAD_BEEF;
    b2b_addr[2] = 32'd7; b2b_exp[2] = 32'h0000_0077;
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1; host_we = 1'b0; host_addr = b2b_addr[i];
      tick();
      check("b2b_rvalid", 32'(host_rvalid), 32'd1);
      check("b2b_rdata", host_rdata, b2b_exp[i]);
    end
    host_valid = 1'b0;
    tick();
    check("b2b_rvalid_end", 32'(host_rvalid), 32'd0);

    // Host read of the word the core stores in the same cycle: pre-edge data
    host_valid = 1'b1; host_we = 1'b0; host_addr = 32'd3;
    RAM_IN_ADDRESS = 32'd3; RAM_IN_DATA = 32'h0000_9999; RAM_IN_WRITE = 1'b1;
    #1 check("rd_vs_wr_ready", 32'(host_ready), 32'd1);
    tick();
    host_valid = 1'b0; RAM_IN_WRITE = 1'b0;
    check("rd_vs_wr_rdata", host_rdata, 32'h0000_1234);
    core_rd_chk("rd_vs_wr_core", 32'd3, 32'h0000_9999);

    // Reset in the acceptance-plus-one cycle
    core_wr(BASE, 32'h0000_00FF);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 32'd5;
    tick();
    host_valid = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("midrst_rvalid", 32'(host_rvalid), 32'd0);
    check("midrst_gpio", gpio_out, 32'd0);
    check("midrst_rdata", host_rdata, 32'd0);
    core_rd_chk("midrst_counter", BASE + 32'd1, 32'd0);
    wait_idle();

    // Reset in the accepting cycle, with a core store that must be dropped
    host_valid = 1'b1; host_we = 1'b0; host_addr = 32'd5;
    RAM_IN_ADDRESS = 32'd10; RAM_IN_DATA = 32'h0000_AAAA; RAM_IN_WRITE = 1'b1;
    clr = 1'b1;
    tick();
    host_valid = 1'b0; RAM_IN_WRITE = 1'b0; clr = 1'b0;
    check("rst_accept_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_accept_rdata", host_rdata, 32'd0);
`ifdef DRAM_CLEAR_EN
    // Clear sweep: busy for exactly DEPTH cycles, host never ready
    busy_cycles = 0;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 32'd2; host_wdata = 32'h0000_0022;
    while (busy && busy_cycles < 100) begin
      check("clear_ready0", 32'(host_ready), 32'd0);
      busy_cycles++;
      tick();
    end
    host_valid = 1'b0; host_we = 1'b0;
    check("clear_busy_cycles", 32'(busy_cycles), 32'(TB_DEPTH));
    core_rd_chk("clear_addr9", 32'd9, 32'd0);
    core_rd_chk("clear_addr2", 32'd2, 32'd0);
`else
    busy_cycles = 0;
    core_rd_chk("retain_addr10", 32'd10, 32'h0000_1010);
    core_rd_chk("retain_addr5", 32'd5, 32'hDEAD_BEEF);
    core_rd_chk("retain_addr9", 32'd9, 32'h0000_0055);
    check("no_clear_busy", 32'(busy_cycles) + 32'(busy), 32'd0);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
